// File: rtl/dmem_host_arb.sv
// Data memory for the core's memory stage with a second host port (four-phase req/ack).
// The core always wins; host writes wait out core write cycles, host reads never wait.
//
// state  | meaning
// H_IDLE | waiting for h_req; request fields are latched when it rises
// H_PEND | latched request outstanding; a write waits while dwr=1
// H_DONE | access finished, h_ack high for this one cycle
// H_REL  | waiting for the host to drop h_req before accepting another request
module dmem_host_arb #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] daddr,
  input  logic          dwr,
  input  logic [DW-1:0] ddout,
  output logic [DW-1:0] ddin,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic [CW-1:0] defer_cnt
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_PEND = 2'd1,
    H_DONE = 2'd2,
    H_REL  = 2'd3
  } h_state_t;

  h_state_t state, state_nxt;

  logic [DW-1:0] mem [DEPTH];

  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic latch_en;
  logic host_wr;
  logic host_rd;
  logic defer_inc;

  // The core registers ddin at the next edge, so the read path stays combinational.
  assign ddin = mem[daddr];

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    defer_inc = 1'b0;
    case (state)
      H_IDLE: begin
        if (h_req) begin
          latch_en  = 1'b1;
          state_nxt = H_PEND;
        end
      end
      H_PEND: begin
        if (lat_we) begin
          if (dwr) begin
            defer_inc = 1'b1;
          end else begin
            host_wr   = 1'b1;
            state_nxt = H_DONE;
          end
        end else begin
          host_rd   = 1'b1;
          state_nxt = H_DONE;
        end
      end
      H_DONE: begin
        state_nxt = H_REL;
      end
      H_REL: begin
        if (!h_req) begin
          state_nxt = H_IDLE;
        end
      end
      default: begin
        state_nxt = H_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= H_IDLE;
      h_ack     <= 1'b0;
      h_rdata   <= '0;
      defer_cnt <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      // Registered ack that is high exactly while the FSM sits in H_DONE.
      h_ack <= (state_nxt == H_DONE);
      if (latch_en) begin
        lat_we    <= h_we;
        lat_addr  <= h_addr;
        lat_wdata <= h_wdata;
      end
      if (host_rd) begin
        h_rdata <= mem[lat_addr];
      end
      if (defer_inc && (defer_cnt != {CW{1'b1}})) begin
        defer_cnt <= defer_cnt + CW'(1);
      end
    end
  end

  // host_wr is only raised when dwr=0, so the two write ports never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (dwr) begin
      mem[daddr] <= ddout;
    end else if (host_wr) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_host_arb.sv
// Self-checking bench for dmem_host_arb: directed vector table, hand sequences for
// deferral / read-during-write / reset corners, and randomized host transactions.
module tb_dmem_host_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  daddr;
  logic        dwr;
  logic [31:0] ddout;
  logic [31:0] ddin;
  logic        h_req;
  logic        h_we;
  logic [5:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_ack;
  logic [31:0] h_rdata;
  logic [15:0] defer_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [64];
  int          defer_mdl;

  dmem_host_arb #(.AW(6), .DW(32), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .daddr     (daddr),
    .dwr       (dwr),
    .ddout     (ddout),
    .ddin      (ddin),
    .h_req     (h_req),
    .h_we      (h_we),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_ack     (h_ack),
    .h_rdata   (h_rdata),
    .defer_cnt (defer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cw;
    logic [5:0]  ca;
    logic [31:0] cd;
    logic        rq;
    logic        we;
    logic [5:0]  ha;
    logic [31:0] hd;
    logic [31:0] e_ddin;
    logic        e_ack;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic cw, input logic [5:0] ca, input logic [31:0] cd,
                              input logic rq, input logic we, input logic [5:0] ha,
                              input logic [31:0] hd, input logic [31:0] e_ddin,
                              input logic e_ack, input logic chk_rd, input logic [31:0] e_rd);
    vec_t v;
    v.cw = cw; v.ca = ca; v.cd = cd; v.rq = rq; v.we = we; v.ha = ha; v.hd = hd;
    v.e_ddin = e_ddin; v.e_ack = e_ack; v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cw, input logic [5:0] ca, input logic [31:0] cd,
                       input logic rq, input logic we, input logic [5:0] ha, input logic [31:0] hd);
    dwr = cw; daddr = ca; ddout = cd;
    h_req = rq; h_we = we; h_addr = ha; h_wdata = hd;
  endtask

  // One clock: drive, check ddin against the model before the edge, apply core write to model.
  task automatic step(input logic cw, input logic [5:0] ca, input logic [31:0] cd,
                      input logic rq, input logic we, input logic [5:0] ha, input logic [31:0] hd);
    drive(cw, ca, cd, rq, we, ha, hd);
    #3;
    chk("ddin", ddin, mdl[ca]);
    @(posedge clk);
    if (cw) mdl[ca] = cd;
    #1;
  endtask

  task automatic do_reset(input logic rq);
    rst = 1'b1;
    drive(1'b0, 6'd0, 32'h0, rq, 1'b1, 6'd0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    defer_mdl = 0;
  endtask

  task automatic rand_txn();
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        cw;
    logic [5:0]  ca;
    int          k;
    int          r;
    we   = 1'($urandom_range(0, 1));
    addr = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
    data = $urandom;
    k    = we ? $urandom_range(0, 3) : 0;
    step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 1'b1, we, addr, data);
    chk("rnd_req_ack", h_ack, 1'b0);
    for (int j = 0; j < k; j++) begin
      ca = ($urandom_range(0, 1) == 1) ? addr : 6'($urandom_range(0, 63));
      step(1'b1, ca, $urandom, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
      chk("rnd_blk_ack", h_ack, 1'b0);
    end
    exp_rd = mdl[addr];
    cw = we ? 1'b0 : 1'($urandom_range(0, 1));
    ca = ($urandom_range(0, 1) == 1) ? addr : 6'($urandom_range(0, 63));
    step(cw, ca, $urandom, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
    chk("rnd_ack", h_ack, 1'b1);
    if (we) mdl[addr] = data;
    else    chk("rnd_rdata", h_rdata, exp_rd);
    defer_mdl += k;
    chk("rnd_defer", {16'h0, defer_cnt}, 32'(defer_mdl));
    r = $urandom_range(0, 2);
    for (int j = 0; j < r; j++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 1'b1, 1'b1,
           6'($urandom_range(0, 63)), $urandom);
      chk("rnd_hold_ack", h_ack, 1'b0);
    end
    for (int j = 0; j < 2; j++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, 1'b0, 1'b0, 6'd0, 32'h0);
      chk("rnd_rel_ack", h_ack, 1'b0);
    end
    if (!we) chk("rnd_rdata_hold", h_rdata, exp_rd);
  endtask

  initial begin
    // cw ca cd | rq we ha hd | e_ddin e_ack chk_rd e_rd
    tbl[0]  = mk(0, 5,  32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0);
    tbl[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0);
    tbl[2]  = mk(0, 5,  32'h0,        0, 0, 0,  32'h0,        32'hDEADBEEF, 0, 0, 32'h0);
    tbl[3]  = mk(0, 10, 32'h0,        1, 1, 10, 32'h12345678, 32'h0,        0, 0, 32'h0);
    tbl[4]  = mk(0, 10, 32'h0,        1, 0, 11, 32'hFFFFFFFF, 32'h0,        1, 0, 32'h0);
    tbl[5]  = mk(0, 10, 32'h0,        1, 0, 11, 32'h0,        32'h12345678, 0, 0, 32'h0);
    tbl[6]  = mk(0, 11, 32'h0,        1, 1, 11, 32'h5,        32'h0,        0, 0, 32'h0);
    tbl[7]  = mk(0, 10, 32'h0,        1, 1, 12, 32'h6,        32'h12345678, 0, 0, 32'h0);
    tbl[8]  = mk(0, 12, 32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0);
    tbl[9]  = mk(0, 5,  32'h0,        1, 0, 10, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0);
    tbl[10] = mk(0, 5,  32'h0,        1, 1, 5,  32'hAAAA,     32'hDEADBEEF, 1, 1, 32'h12345678);
    tbl[11] = mk(0, 5,  32'h0,        0, 0, 0,  32'h0,        32'hDEADBEEF, 0, 1, 32'h12345678);
    tbl[12] = mk(0, 12, 32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 1, 32'h12345678);
    tbl[13] = mk(1, 63, 32'hA5A5A5A5, 0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0);
    tbl[14] = mk(0, 0,  32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0, 32'h0);
    tbl[15] = mk(0, 63, 32'h0,        0, 0, 0,  32'h0,        32'hA5A5A5A5, 0, 0, 32'h0);

    do_reset(1'b0);
    chk("rst_ack", h_ack, 1'b0);
    chk("rst_rdata", h_rdata, 32'h0);
    chk("rst_defer", {16'h0, defer_cnt}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].rq, tbl[i].we, tbl[i].ha, tbl[i].hd);
      #3;
      chk($sformatf("tbl%0d_ddin", i), ddin, tbl[i].e_ddin);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ack", i), h_ack, tbl[i].e_ack);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), h_rdata, tbl[i].e_rd);
    end

    // Host write to 3 deferred by four core-write cycles to the same word.
    do_reset(1'b0);
    step(0, 3, 32'h0, 1, 1, 3, 32'hCAFE0003);
    chk("defer_req_ack", h_ack, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(1, 3, 32'h11110000 + 32'(j), 1, 0, 9, 32'hBAD);
      chk("defer_blk_ack", h_ack, 1'b0);
      chk("defer_cnt_run", {16'h0, defer_cnt}, 32'(j + 1));
    end
    step(0, 3, 32'h0, 1, 0, 0, 32'h0);
    chk("defer_ack", h_ack, 1'b1);
    chk("defer_cnt", {16'h0, defer_cnt}, 32'd4);
    mdl[3] = 32'hCAFE0003;
    step(0, 3, 32'h0, 0, 0, 0, 32'h0);
    step(0, 3, 32'h0, 0, 0, 0, 32'h0);
    chk("defer_mem3", ddin, 32'hCAFE0003);

    // Host read of 7 in the same cycle the core writes 7.
    step(1, 7, 32'h1, 0, 0, 0, 32'h0);
    step(0, 7, 32'h0, 1, 0, 7, 32'h0);
    step(1, 7, 32'h2, 1, 1, 8, 32'h9);
    chk("rdw_ack", h_ack, 1'b1);
    chk("rdw_rdata", h_rdata, 32'h1);
    step(0, 7, 32'h0, 0, 0, 0, 32'h0);
    step(0, 7, 32'h0, 0, 0, 0, 32'h0);

    // Reset while a deferred write is pending.
    step(0, 40, 32'h0, 1, 1, 40, 32'h77);
    step(1, 0, 32'h5, 1, 1, 40, 32'h77);
    chk("mid_blk_ack", h_ack, 1'b0);
    do_reset(1'b0);
    chk("mid_rst_ack", h_ack, 1'b0);
    chk("mid_rst_defer", {16'h0, defer_cnt}, 32'h0);
    chk("mid_rst_rdata", h_rdata, 32'h0);
    for (int j = 0; j < 4; j++) begin
      step(0, 40, 32'h0, 0, 0, 0, 32'h0);
      chk("mid_idle_ack", h_ack, 1'b0);
    end
    step(0, 40, 32'h0, 1, 1, 40, 32'h77);
    step(0, 40, 32'h0, 1, 1, 40, 32'h77);
    chk("mid_new_ack", h_ack, 1'b1);
    mdl[40] = 32'h77;
    step(0, 40, 32'h0, 0, 0, 0, 32'h0);
    step(0, 40, 32'h0, 0, 0, 0, 32'h0);

    // Request held high through reset counts as a fresh request.
    step(0, 0, 32'h0, 1, 0, 40, 32'h0);
    do_reset(1'b1);
    step(0, 0, 32'h0, 1, 0, 40, 32'h0);
    chk("held_req_ack0", h_ack, 1'b0);
    step(0, 0, 32'h0, 1, 0, 40, 32'h0);
    chk("held_req_ack", h_ack, 1'b1);
    chk("held_req_rdata", h_rdata, 32'h0);
    step(0, 0, 32'h0, 0, 0, 0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 0, 32'h0);

    do_reset(1'b0);
    for (int t = 0; t < 60; t++) begin
      rand_txn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_host_arb.md
Name: dmem_host_arb

Overview:
- Data memory that sits directly downstream of the pipelined MIPS core's memory stage: the core's daddr/dwr/ddout drive it, and its ddin output feeds the core.
- Adds a second, host-side port with a four-phase req/ack handshake, used by the testbench/debug host to preload or inspect data memory while the core runs.
- The core has absolute priority; the host port arbitrates around core writes.

Parameters:
- AW, 6, address width; depth is 2**AW words.
- DW, 32, data word width.
- CW, 16, width of the host-deferral counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- daddr  input  AW  core word address.
- dwr  input  1  core write enable.
- ddout  input  DW  core write data (core's store data output).
- ddin  output  DW  core read data.
- h_req  input  1  host request, held high until h_ack is seen.
- h_we  input  1  host write (1) / read (0); sampled with h_req.
- h_addr  input  AW  host word address; sampled with h_req.
- h_wdata  input  DW  host write data; sampled with h_req.
- h_ack  output  1  host completion strobe (registered).
- h_rdata  output  DW  host read data, valid while h_ack=1 and held afterwards.
- defer_cnt  output  CW  count of cycles a host write was blocked by a core write.

Behaviour:
- Storage: 2**AW x DW array. Synchronous reset (rst=1 at a clock edge) clears every word to 0.
- Core read is combinational: ddin = mem[daddr] in the same cycle. This is required because the core registers ddin at the next edge.
- Core write: on a clock edge with dwr=1, mem[daddr] <= ddout.
- Read-during-write: ddin shows the old contents until the edge. A host read of an address the core is writing in the same cycle also returns the old value.
- Host FSM states: H_IDLE, H_PEND, H_DONE, H_REL.
  - H_IDLE: if h_req=1, latch h_we/h_addr/h_wdata and go to H_PEND.
  - H_PEND, write request: if dwr=1, stay in H_PEND and increment defer_cnt (saturating at all-ones). Else write the latched word and go to H_DONE.
  - H_PEND, read request: never blocked. Capture mem[latched addr] into h_rdata (pre-edge value) and go to H_DONE.
  - H_DONE: h_ack=1 for exactly this state. Go to H_REL.
  - H_REL: h_ack=0. Wait for h_req=0, then go to H_IDLE.
- Latency: h_req seen at edge N; access performed at edge N+1 if unblocked; h_ack is high in the cycle after edge N+1.
- Host write and core write to the same address are never simultaneous, because the host defers. Host data therefore lands strictly after the core write.
- h_ack is never asserted in any state other than H_DONE.
- Reset mid-handshake: FSM goes to H_IDLE; h_ack=0, h_rdata=0, defer_cnt=0; the latched request is discarded. A request still held high after reset is treated as a new request.
- Reset values: h_ack=0, h_rdata=0, defer_cnt=0, FSM=H_IDLE. ddin reads 0 after reset because memory is cleared.
- Address wrap: addresses are exactly AW bits, with no out-of-range case. Address 63 is valid and distinct from 0.
- h_we/h_addr/h_wdata changing after the latching edge have no effect.

Test Plan:
- Reset then core read: rst 1 cycle; daddr=5 -> ddin=0. Core write dwr=1, daddr=5, ddout=0xDEADBEEF; next cycle daddr=5 -> ddin=0xDEADBEEF.
- Host write/read: h_req=1, h_we=1, h_addr=10, h_wdata=0x12345678 with dwr=0 -> h_ack high 2 cycles after the req edge, for exactly 1 cycle. Then core daddr=10 -> ddin=0x12345678. Host read of addr 10 -> h_rdata=0x12345678 at h_ack.
- Deferral: host write addr 3 while the core holds dwr=1 for 4 cycles -> h_ack delayed by 4 cycles, defer_cnt=4, and the host value remains in mem[3] afterwards.
- Same-cycle read-during-write: mem[7]=0x1; core writes 0x2 to addr 7 while a host read of addr 7 is in H_PEND -> h_rdata=0x1; core read of addr 7 next cycle -> 0x2.
- Four-phase release: keep h_req=1 after ack for 3 cycles -> no second ack. Drop h_req, then raise it again -> a new transaction completes.
- Reset mid-operation: assert rst while in H_PEND (deferred by dwr) -> h_ack=0, defer_cnt=0, mem[addr] stays 0, and no ack follows unless h_req is re-presented.
